// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: byte width and sequencer states.
// No logic; pure type and constant definitions.
// Imported by the arbiter top and its round-robin helper.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    FETCH     = 3'd2,
    ISSUE     = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin priority select: first set request at or above ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is sampled.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  // Walk the request vector starting at ptr; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte streams, round-robin per message.
// Latency: 3 cycles from request in IDLE to tx_en; busy duration + 3 between bytes.
// Backpressure: req_ready strobes once per byte; the grant is held until a last byte completes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_en,
  input  logic                      tx_busy,
  output logic                      active
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] IDX_MAX  = PTR_W'(NUM_REQ - 1);

  state_t              state, state_d;
  logic [NUM_REQ-1:0]  grant_q, arb_gnt;
  logic [PTR_W-1:0]    gidx_q, arb_idx, rr_ptr;
  logic [BYTE_W-1:0]   tx_data_q, cur_data;
  logic                last_q, active_q, cur_valid, cur_last;
  logic [TMR_W-1:0]    timer;
  logic                do_arb, do_accept, do_release, clr_timer, inc_timer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Binary index of the arbiter winner, kept so the owner's lanes can be muxed cheaply.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign cur_valid = req_valid[gidx_q];
  assign cur_last  = req_last[gidx_q];
  assign cur_data  = req_data[gidx_q*BYTE_W +: BYTE_W];

  // Sequencer state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and strobe decode; tx_en and req_ready are single-cycle decodes of the state.
  always_comb begin
    state_d    = state;
    do_arb     = 1'b0;
    do_accept  = 1'b0;
    do_release = 1'b0;
    clr_timer  = 1'b0;
    inc_timer  = 1'b0;
    req_ready  = '0;
    tx_en      = 1'b0;
    case (state)
      IDLE: begin
        // A busy transmitter here belongs to someone else (or a byte left over from reset).
        if (|req_valid && !tx_busy) state_d = ARB;
      end
      ARB: begin
        // Fall back to IDLE if the request vanished rather than latch an empty grant.
        if (|arb_gnt) begin
          do_arb  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        // A gap mid-message just waits here; the grant is never dropped before the last byte.
        if (cur_valid) begin
          do_accept = 1'b1;
          req_ready = grant_q;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        tx_en     = 1'b1;
        clr_timer = 1'b1;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A transmitter that never raises busy is assumed to have sent the byte after the timeout.
        if (tx_busy)                state_d = WAIT_DONE;
        else if (timer >= TMR_LAST) state_d = WAIT_DONE;
        else                        inc_timer = 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            do_release = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d    = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ownership: latch the winner, release it after its last byte and rotate priority past it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr   <= '0;
      active_q <= 1'b0;
    end else if (do_arb) begin
      grant_q  <= arb_gnt;
      gidx_q   <= arb_idx;
      active_q <= 1'b1;
    end else if (do_release) begin
      grant_q  <= '0;
      active_q <= 1'b0;
      rr_ptr   <= (gidx_q == IDX_MAX) ? '0 : gidx_q + 1'b1;
    end
  end

  // Byte register: only loads on accept, so tx_data cannot move while the transmitter is busy.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
      last_q    <= 1'b0;
    end else if (do_accept) begin
      tx_data_q <= cur_data;
      last_q    <= cur_last;
    end
  end

  // Acknowledge timer; saturates instead of wrapping.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                          timer <= '0;
    else if (clr_timer)                  timer <= '0;
    else if (inc_timer && (timer != '1)) timer <= timer + 1'b1;
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign active  = active_q;

endmodule
